// File: rtl/simple_uart_rx.sv
// simple_uart_rx: 8N1 oversampling receiver, one-byte holding register, Wishbone-style read port.
// Latency: byte lands in dat_o one edge after the stop-bit sample tick (one tick later with SIMPLE_UART_RX_MAJORITY_EN).
// Backpressure: none; an unread byte is overwritten and flagged by overrun; ack_o is combinational, no wait states.
module simple_uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    output logic       ack_o,
    input  logic       we_i,
    output logic [7:0] dat_o,
    input  logic       cs_i,
    input  logic       baud16x_ce,
    input  logic       baud8x,
    input  logic       clear,
    input  logic       rxd,
    output logic       data_present,
    output logic       frame_err,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [4:0]             cnt, cnt_nxt, cnt_inc, half, full, lim;
    logic [2:0]             bit_idx, bit_idx_nxt;
    logic [7:0]             shift, shift_nxt;
    logic                   samp_pt, bit_val, done;
    logic                   access, rd, wr;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign half    = baud8x ? 5'd4 : 5'd8;
    assign full    = baud8x ? 5'd8 : 5'd16;
    assign lim     = (state == START) ? half : full;
    assign cnt_inc = cnt + 5'd1;

    assign access = cyc_i & stb_i & cs_i;
    assign rd     = access & ~we_i;
    assign wr     = access & we_i;
    assign ack_o  = access;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else if (clear) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

`ifdef SIMPLE_UART_RX_MAJORITY_EN
    // Decision lands one tick past the nominal point; restarting at 1 keeps the bit grid from drifting.
    localparam logic [4:0] CNT_RESTART = 5'd1;
    logic [1:0] votes;

    assign samp_pt = (cnt_inc == lim + 5'd1);
    assign bit_val = (votes[0] & votes[1]) | (votes[0] & rxs) | (votes[1] & rxs);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            votes <= '1;
        end else if (clear) begin
            votes <= '1;
        end else if (baud16x_ce) begin
            if (cnt_inc == lim - 5'd1) votes[0] <= rxs;
            if (cnt_inc == lim)        votes[1] <= rxs;
        end
    end
`else
    localparam logic [4:0] CNT_RESTART = 5'd0;

    assign samp_pt = (cnt_inc == lim);
    assign bit_val = rxs;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        done        = 1'b0;
        if (baud16x_ce) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nxt = START;
                        cnt_nxt   = '0;
                    end
                end
                START: begin
                    if (samp_pt) begin
                        cnt_nxt = CNT_RESTART;
                        if (bit_val) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt   = DATA;
                            bit_idx_nxt = '0;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                DATA: begin
                    if (samp_pt) begin
                        cnt_nxt   = CNT_RESTART;
                        shift_nxt = {bit_val, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            bit_idx_nxt = bit_idx + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                STOP: begin
                    if (samp_pt) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (clear) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    // A completing byte beats a same-cycle read or write-clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_o        <= '0;
            data_present <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else if (clear) begin
            dat_o        <= '0;
            data_present <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (done) begin
                dat_o        <= shift;
                data_present <= 1'b1;
                frame_err    <= ~bit_val;
            end else begin
                if (rd) data_present <= 1'b0;
                if (wr) frame_err    <= 1'b0;
            end
            if (done && data_present && !rd) begin
                overrun <= 1'b1;
            end else if (wr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_simple_uart_rx.sv
// Scoreboard bench for simple_uart_rx: stimulus queues expected bytes, a negedge monitor checks each delivery.
module tb_simple_uart_rx;
    logic       clk_i = 1'b0;
    logic       rst_i, cyc_i, stb_i, we_i, cs_i, baud16x_ce, baud8x, clear, rxd;
    logic       ack_o, data_present, frame_err, overrun;
    logic [7:0] dat_o;

    int         tests = 0;
    int         fails = 0;
    int         bit_clks = 16;
    logic [8:0] exp_q[$];
    logic       prev_dp = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    always #5 clk_i = ~clk_i;

    simple_uart_rx #(.SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
        .we_i(we_i), .dat_o(dat_o), .cs_i(cs_i), .baud16x_ce(baud16x_ce),
        .baud8x(baud8x), .clear(clear), .rxd(rxd), .data_present(data_present),
        .frame_err(frame_err), .overrun(overrun)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        exp_q.push_back({~stop_bit, b});
        rxd = 1'b0;
        step(bit_clks);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(bit_clks);
        end
        rxd = stop_bit;
        step(bit_clks);
        rxd = 1'b1;
    endtask

    task automatic wait_dp(input int budget);
        int n = 0;
        while (!data_present && n < budget) begin
            step(1);
            n++;
        end
        check("dp_within_budget", 8'(data_present), 8'd1);
    endtask

    task automatic bus(input logic we, input string name);
        cyc_i = 1'b1; stb_i = 1'b1; cs_i = 1'b1; we_i = we;
        @(negedge clk_i);
        check({name, "_ack"}, 8'(ack_o), 8'd1);
        step(1);
        cyc_i = 1'b0; stb_i = 1'b0; cs_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        check({name, "_ack_drop"}, 8'(ack_o), 8'd0);
        step(1);
    endtask

    // Delivery = data_present rising, or a new byte replacing an unread one.
    always @(negedge clk_i) begin
        if (!rst_i && data_present && (!prev_dp || dat_o != prev_dat)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got 0x%02h, expected none", dat_o);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("rx_byte", dat_o, e[7:0]);
                check("rx_frame_err", 8'(frame_err), {7'd0, e[8]});
            end
        end
        prev_dp  = data_present;
        prev_dat = dat_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cs_i = 1'b0;
        baud16x_ce = 1'b1; baud8x = 1'b0; clear = 1'b0; rxd = 1'b1;
        step(3);
        rst_i = 1'b0;
        step(2);
        check("rst_dat", dat_o, 8'h00);
        check("rst_dp", 8'(data_present), 8'd0);
        check("rst_fe", 8'(frame_err), 8'd0);
        check("rst_ov", 8'(overrun), 8'd0);
        check("rst_ack", 8'(ack_o), 8'd0);

        // Good frame, then read drains it while dat_o holds.
        send(8'h55, 1'b1);
        wait_dp(20);
        check("b55_fe", 8'(frame_err), 8'd0);
        bus(1'b0, "rd55");
        check("rd55_dp_clr", 8'(data_present), 8'd0);
        check("rd55_dat_hold", dat_o, 8'h55);
        step(20);

        // Bad stop bit: byte still loaded, frame_err set until write.
        send(8'hA3, 1'b0);
        wait_dp(20);
        check("bA3_fe", 8'(frame_err), 8'd1);
        check("bA3_dat", dat_o, 8'hA3);
        bus(1'b1, "wrA3");
        check("wrA3_fe_clr", 8'(frame_err), 8'd0);
        check("wrA3_dp_kept", 8'(data_present), 8'd1);
        bus(1'b0, "rdA3");
        step(20);

        // Two bytes without a read in between.
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        wait_dp(20);
        check("ovr_flag", 8'(overrun), 8'd1);
        check("ovr_dat", dat_o, 8'h34);
        check("ovr_dp", 8'(data_present), 8'd1);
        bus(1'b0, "rd34");
        bus(1'b1, "wr34");
        check("ovr_clr", 8'(overrun), 8'd0);
        check("ovr_dp_clr", 8'(data_present), 8'd0);
        step(20);

        // Short glitch is rejected as a false start.
        rxd = 1'b0;
        step(4);
        rxd = 1'b1;
        step(60);
        check("glitch_dp", 8'(data_present), 8'd0);

        // 8 ticks per bit.
        baud8x = 1'b1;
        bit_clks = 8;
        send(8'hC6, 1'b1);
        wait_dp(20);
        check("bC6_dat", dat_o, 8'hC6);
        step(10);

        // Soft clear mid-frame wipes the unread byte and flags.
        rxd = 1'b0;
        step(12);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        rxd = 1'b1;
        step(2);
        check("clr_dp", 8'(data_present), 8'd0);
        check("clr_fe", 8'(frame_err), 8'd0);
        check("clr_ov", 8'(overrun), 8'd0);
        check("clr_dat", dat_o, 8'h00);
        step(40);

        send(8'h7E, 1'b1);
        wait_dp(20);
        check("b7E_dat", dat_o, 8'h7E);
        bus(1'b0, "rd7E");
        step(20);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_bytes: got %0d undelivered, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
